// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the 8-bit single-cycle core: opcode values, ALU
//   select encoding and the bit positions of the instruction fields.
//   Instruction layout: OP=[31:24] RD=[23:16] RT=[15:8] RS/imm=[7:0].
//   Only the low REG_AW bits of each register field select a register.
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int DATA_W  = 8;
   localparam int INSTR_W = 32;
   localparam int REG_AW  = 3;
   localparam int NUM_REG = 8;

   // Field slice positions
   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 24;
   localparam int RD_LSB  = 16;
   localparam int RT_LSB  = 8;
   localparam int RS_LSB  = 0;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   // Opcodes
   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;

   // ALU select: FWD passes operand B straight through (loadi / mov)
   typedef enum logic [1:0] {
      ALU_FWD = 2'd0,
      ALU_ADD = 2'd1,
      ALU_AND = 2'd2,
      ALU_OR  = 2'd3
   } alu_sel_t;

endpackage

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   8 x 8-bit register file, two combinational read ports, one write port.
//   Writes land on the rising clock edge; a same-cycle read of the register
//   being written returns the old value. Synchronous reset clears all entries
//   and suppresses the write on that edge.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   we       in   write enable
//   waddr    in   write address (3 bits)
//   wdata    in   write data (8 bits)
//   raddr_a  in   read port A address
//   rdata_a  out  read port A data
//   raddr_b  in   read port B address
//   rdata_b  out  read port B data
// -----------------------------------------------------------------------------
module reg_file
   import cpu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   logic [DATA_W-1:0] regs [NUM_REG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REG; i++) begin
            regs[i] <= '0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/cpu_8bit.sv
// -----------------------------------------------------------------------------
// cpu_8bit
//   Single-cycle 8-bit core. Each clock: the instruction at PC is decoded,
//   two registers are read, the ALU computes, and the result is written back
//   on the next rising edge while PC advances by 4. Unknown opcodes are NOPs.
// Ports:
//   CLK          in   system clock, rising-edge
//   RESET        in   synchronous active-high reset (PC=0, registers=0)
//   PC           out  32-bit byte address of the current instruction
//   INSTRUCTION  in   32-bit instruction word fetched from PC
// -----------------------------------------------------------------------------
module cpu_8bit
   import cpu_pkg::*;
(
   input  logic               CLK,
   input  logic               RESET,
   output logic [INSTR_W-1:0] PC,
   input  logic [INSTR_W-1:0] INSTRUCTION
);

   // Field extraction
   logic [7:0]        op;
   logic [REG_AW-1:0] rd_addr;
   logic [REG_AW-1:0] rt_addr;
   logic [REG_AW-1:0] rs_addr;
   logic [DATA_W-1:0] imm;

   assign op      = INSTRUCTION[OP_MSB:OP_LSB];
   assign rd_addr = INSTRUCTION[RD_LSB+REG_AW-1:RD_LSB];
   assign rt_addr = INSTRUCTION[RT_LSB+REG_AW-1:RT_LSB];
   assign rs_addr = INSTRUCTION[RS_LSB+REG_AW-1:RS_LSB];
   assign imm     = INSTRUCTION[IMM_MSB:IMM_LSB];

   // Upper bits of the register fields are architecturally ignored
   logic unused_field_bits;
   assign unused_field_bits = ^{INSTRUCTION[23:19], INSTRUCTION[15:11]};

   // Decode
   logic     reg_we;
   logic     use_imm;
   logic     negate_b;
   alu_sel_t alu_sel;

   always_comb begin
      reg_we   = 1'b0;
      use_imm  = 1'b0;
      negate_b = 1'b0;
      alu_sel  = ALU_FWD;
      case (op)
         OP_LOADI: begin reg_we = 1'b1; use_imm = 1'b1; alu_sel = ALU_FWD; end
         OP_MOV:   begin reg_we = 1'b1; alu_sel = ALU_FWD; end
         OP_ADD:   begin reg_we = 1'b1; alu_sel = ALU_ADD; end
         OP_SUB:   begin reg_we = 1'b1; negate_b = 1'b1; alu_sel = ALU_ADD; end
         OP_AND:   begin reg_we = 1'b1; alu_sel = ALU_AND; end
         OP_OR:    begin reg_we = 1'b1; alu_sel = ALU_OR;  end
         default:  begin reg_we = 1'b0; end
      endcase
   end

   // Register file: port A = RT, port B = RS
   logic [DATA_W-1:0] rt_data;
   logic [DATA_W-1:0] rs_data;
   logic [DATA_W-1:0] wb_data;

   reg_file u_reg_file (
      .clk     (CLK),
      .rst     (RESET),
      .we      (reg_we),
      .waddr   (rd_addr),
      .wdata   (wb_data),
      .raddr_a (rt_addr),
      .rdata_a (rt_data),
      .raddr_b (rs_addr),
      .rdata_b (rs_data)
   );

   // Operand muxes; subtraction reuses the adder with a negated B operand
   logic signed [DATA_W-1:0] op_a;
   logic signed [DATA_W-1:0] op_b_raw;
   logic signed [DATA_W-1:0] op_b;
   logic signed [DATA_W-1:0] alu_res;

   assign op_a     = $signed(rt_data);
   assign op_b_raw = use_imm ? $signed(imm) : $signed(rs_data);
   assign op_b     = negate_b ? -op_b_raw : op_b_raw;

   // 8-bit ALU; sums wrap modulo 256
   function automatic logic signed [DATA_W-1:0] alu_op(
      input alu_sel_t                 sel,
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      case (sel)
         ALU_ADD: alu_op = a + b;
         ALU_AND: alu_op = a & b;
         ALU_OR:  alu_op = a | b;
         default: alu_op = b;
      endcase
   endfunction

   assign alu_res = alu_op(alu_sel, op_a, op_b);
   assign wb_data = alu_res;

   // PC register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         PC <= '0;
      end else begin
         PC <= PC + 32'd4;
      end
   end

endmodule

// File: tb/tb_cpu_8bit.sv
module tb_cpu_8bit;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [31:0] PC;
   logic [31:0] INSTRUCTION = 32'hFF00_0000;

   int n_vec  = 0;
   int n_miss = 0;

   cpu_8bit dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .PC          (PC),
      .INSTRUCTION (INSTRUCTION)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rf(input int idx);
      return dut.u_reg_file.regs[idx];
   endfunction

   // Apply one instruction for one cycle; sample 1 time unit after the edge
   task automatic exec(input logic [31:0] ins);
      INSTRUCTION = ins;
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_reset(input logic [31:0] ins);
      INSTRUCTION = ins;
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
   endtask

   task automatic chk_all_regs(input string tag, input logic [7:0] exp [8]);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s_r%0d", tag, i), {24'd0, rf(i)}, {24'd0, exp[i]});
      end
   endtask

   logic [7:0] exp_r [8];

   initial begin
      // 1: reset, then NOPs advance PC
      pulse_reset(32'hFF00_0000);
      chk("rst_pc", PC, 32'd0);
      exp_r = '{default: 8'h00};
      chk_all_regs("rst", exp_r);
      exec(32'hFF00_0000); chk("pc4",  PC, 32'd4);
      exec(32'hFF00_0000); chk("pc8",  PC, 32'd8);
      exec(32'hFF00_0000); chk("pc12", PC, 32'd12);

      // 2: loadi / add
      exec(32'h0004_0005); chk("loadi_r4", {24'd0, rf(4)}, 32'h05);
      exec(32'h0002_0009); chk("loadi_r2", {24'd0, rf(2)}, 32'h09);
      exec(32'h0206_0402); chk("add_r6",   {24'd0, rf(6)}, 32'h0E);
      chk("pc24", PC, 32'd24);

      // 3: sub, including wrap below zero
      exec(32'h0301_0204); chk("sub_r1", {24'd0, rf(1)}, 32'h04);
      exec(32'h0300_0402); chk("sub_r0", {24'd0, rf(0)}, 32'hFC);

      // 4: logic ops and mov
      exec(32'h0003_00F0); chk("loadi_r3", {24'd0, rf(3)}, 32'hF0);
      exec(32'h0005_003C); chk("loadi_r5", {24'd0, rf(5)}, 32'h3C);
      exec(32'h0407_0305); chk("and_r7",   {24'd0, rf(7)}, 32'h30);
      exec(32'h0501_0305); chk("or_r1",    {24'd0, rf(1)}, 32'hFC);
      exec(32'h0102_0007); chk("mov_r2",   {24'd0, rf(2)}, 32'h30);
      chk("pc52", PC, 32'd52);

      // 5: RD==RT==RS with overflow wrap, then an unknown opcode
      exec(32'h0004_0080); chk("loadi_r4_80", {24'd0, rf(4)}, 32'h80);
      exec(32'h0204_0404); chk("add_self_r4", {24'd0, rf(4)}, 32'h00);
      exec(32'hFF06_0102);
      chk("nop_pc", PC, 32'd64);
      exp_r = '{8'hFC, 8'hFC, 8'h30, 8'hF0, 8'h00, 8'h3C, 8'h0E, 8'h30};
      chk_all_regs("nop", exp_r);

      // Upper bits of RD field ignored: 0x0E selects r6
      exec(32'h000E_0011); chk("rd_hi_bits_r6", {24'd0, rf(6)}, 32'h11);
      chk("rd_hi_bits_r0", {24'd0, rf(0)}, 32'hFC);

      // 6: reset mid-program at PC=0x10 discards the in-flight write
      pulse_reset(32'hFF00_0000);
      exec(32'h0000_0001);
      exec(32'h0001_0002);
      exec(32'h0002_0003);
      exec(32'h0003_0004);
      chk("pre_rst_pc", PC, 32'h10);
      chk("pre_rst_r3", {24'd0, rf(3)}, 32'h04);
      pulse_reset(32'h0007_0055);
      chk("mid_rst_pc", PC, 32'd0);
      exp_r = '{default: 8'h00};
      chk_all_regs("mid_rst", exp_r);
      exec(32'h0001_0022);
      chk("resume_pc", PC, 32'd4);
      chk("resume_r1", {24'd0, rf(1)}, 32'h22);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
